// File: rtl/imuldiv_int_mul_iterative_param_if.sv
// -----------------------------------------------------------------------------
// imuldiv_int_mul_iterative_param_if
//
// Request/response bundle for the iterative integer multiplier.
//
// Parameters:
//   W                   operand width. It must match W on the multiplier.
//
// Signals:
//   mulreq_msg_a        [W-1:0]    operand A (multiplicand)
//   mulreq_msg_b        [W-1:0]    operand B (multiplier)
//   mulreq_msg_signed              1 = two's-complement operands, 0 = unsigned
//   mulreq_val / mulreq_rdy        request handshake
//   mulresp_msg_result  [2W-1:0]   product
//   mulresp_val / mulresp_rdy      response handshake
//
// Modports:
//   master   the requester (issue logic / writeback side)
//   slave    the multiplier
// -----------------------------------------------------------------------------
interface imuldiv_int_mul_iterative_param_if #(
    parameter int W = 32
);
    logic [W-1:0]   mulreq_msg_a;
    logic [W-1:0]   mulreq_msg_b;
    logic           mulreq_msg_signed;
    logic           mulreq_val;
    logic           mulreq_rdy;
    logic [2*W-1:0] mulresp_msg_result;
    logic           mulresp_val;
    logic           mulresp_rdy;

    modport master (
        output mulreq_msg_a,
        output mulreq_msg_b,
        output mulreq_msg_signed,
        output mulreq_val,
        input  mulreq_rdy,
        input  mulresp_msg_result,
        input  mulresp_val,
        output mulresp_rdy
    );

    modport slave (
        input  mulreq_msg_a,
        input  mulreq_msg_b,
        input  mulreq_msg_signed,
        input  mulreq_val,
        output mulreq_rdy,
        output mulresp_msg_result,
        output mulresp_val,
        input  mulresp_rdy
    );
endinterface

// File: rtl/imuldiv_int_mul_iterative_param.sv
// -----------------------------------------------------------------------------
// imuldiv_int_mul_iterative_param
//
// Iterative shift-add integer multiplier. It retires one multiplier bit per
// cycle and produces a 2W-bit product. Each request selects signed or unsigned
// operands. Signed products are formed by multiplying magnitudes and then
// negating the result when the operand signs differ.
//
// Parameters:
//   W    operand width, legal range 4..64. The result is 2W bits.
//   CW   iteration counter width. It is derived from W and is not overridden.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous reset, active low
//   bus     request/response bundle (slave side), with the same W as here
//
// Build option:
//   IMULDIV_MUL_EARLY_EXIT_EN  When this macro is defined, CALC also finishes
//                              at the edge where the shifted multiplier becomes
//                              zero. Latency is then 1 + max(1, msb(|B|) + 1).
//                              When it is undefined, latency is always W+1.
//                              The product is the same in both builds.
// -----------------------------------------------------------------------------
module imuldiv_int_mul_iterative_param #(
    parameter int W  = 32,
    parameter int CW = $clog2(W + 1)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    imuldiv_int_mul_iterative_param_if.slave        bus
);

    localparam int             W2   = 2 * W;
    localparam logic [CW-1:0]  LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [W2-1:0]   a_q,     a_d;      // shifted multiplicand magnitude
    logic [W-1:0]    b_q,     b_d;      // remaining multiplier magnitude bits
    logic [W2-1:0]   res_q,   res_d;    // unsigned partial-product sum
    logic [CW-1:0]   count_q, count_d;
    logic            neg_q,   neg_d;    // final product must be negated

    // In signed mode, the most negative input maps to 2^(W-1). That value still
    // fits in W unsigned bits, so no extra width is needed.
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] x,
                                               input logic         is_signed);
        return (is_signed && x[W-1]) ? (~x + W'(1)) : x;
    endfunction

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal this block writes gets a default first. If any
        // path left one of them unassigned, synthesis would infer a latch.
        state_d         = state_q;
        a_d             = a_q;
        b_d             = b_q;
        res_d           = res_q;
        count_d         = count_q;
        neg_d           = neg_q;
        bus.mulreq_rdy  = 1'b0;
        bus.mulresp_val = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bus.mulreq_rdy = 1'b1;
                if (bus.mulreq_val) begin
                    a_d     = {{W{1'b0}}, magnitude(bus.mulreq_msg_a, bus.mulreq_msg_signed)};
                    b_d     = magnitude(bus.mulreq_msg_b, bus.mulreq_msg_signed);
                    res_d   = '0;
                    count_d = '0;
                    neg_d   = bus.mulreq_msg_signed
                              && (bus.mulreq_msg_a[W-1] ^ bus.mulreq_msg_b[W-1]);
                    state_d = ST_CALC;
                end
            end

            ST_CALC: begin
                // The sum of the partial products is bounded by
                // (2^W - 1)^2 < 2^(2W), so this addition cannot wrap.
                if (b_q[0]) begin
                    res_d = res_q + a_q;
                end
                a_d     = a_q << 1;
                b_d     = b_q >> 1;
                count_d = count_q + CW'(1);
`ifdef IMULDIV_MUL_EARLY_EXIT_EN
                // If no multiplier bits remain after this shift, the product
                // is already complete.
                if ((count_q == LAST) || ((b_q >> 1) == '0)) begin
                    state_d = ST_DONE;
                end
`else
                if (count_q == LAST) begin
                    state_d = ST_DONE;
                end
`endif
            end

            ST_DONE: begin
                bus.mulresp_val = 1'b1;
                if (bus.mulresp_rdy) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The sign correction is combinational from the registered magnitude, so
    // the result stays stable for as long as back-pressure holds DONE.
    // After reset, every register is zero, so this output reads zero.
    assign bus.mulresp_msg_result = neg_q ? (~res_q + W2'(1)) : res_q;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: the datapath registers are reset together with the FSM. This way,
    // an aborted operation leaves no residue on the result output, which is
    // visible combinationally while the design is idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            count_q <= '0;
            neg_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only. All
            // registers then update together from the values before the edge.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            count_q <= count_d;
            neg_q   <= neg_d;
        end
    end

endmodule

// File: tb/tb_imuldiv_int_mul_iterative_param.sv
// -----------------------------------------------------------------------------
// tb_imuldiv_int_mul_iterative_param
//
// Directed, self-checking bench. It covers a W=32 instance and a W=8 instance.
// -----------------------------------------------------------------------------
module tb_imuldiv_int_mul_iterative_param;

    logic clk;
    logic reset;

    int n_checks;
    int n_fail;
    int cyc;

    imuldiv_int_mul_iterative_param_if #(.W(32)) if32 ();
    imuldiv_int_mul_iterative_param_if #(.W(8))  if8  ();

    imuldiv_int_mul_iterative_param #(.W(32)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (if32)
    );

    imuldiv_int_mul_iterative_param #(.W(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Expected latency for one request. In the default build it is W+1.
    function automatic int exp_lat(input logic [63:0] mag_b, input int w);
        int n;
        n = 0;
        for (int i = 0; i < w; i++) if (mag_b[i]) n = i + 1;
`ifdef IMULDIV_MUL_EARLY_EXIT_EN
        return 1 + ((n < 1) ? 1 : n);
`else
        return w + 1;
`endif
    endfunction

    // Runs one W=32 request. The response is held off for `hold` cycles after
    // mulresp_val rises.
    task automatic mul32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] exp_res, input int hold);
        int          lat;
        logic [63:0] res;
        logic        stable;
        logic [31:0] mb;
        @(negedge clk);
        if32.mulreq_msg_a      = a;
        if32.mulreq_msg_b      = b;
        if32.mulreq_msg_signed = sgn;
        if32.mulreq_val        = 1'b1;
        if32.mulresp_rdy       = (hold == 0);
        @(posedge clk); #1;
        if32.mulreq_val   = 1'b0;
        if32.mulreq_msg_a = 32'hDEAD_BEEF;  // operands may change after acceptance
        if32.mulreq_msg_b = 32'h5A5A_A5A5;
        lat = 1;
        while (!if32.mulresp_val && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        mb = (sgn && b[31]) ? (~b + 32'd1) : b;
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat(64'(mb), 32)));
        res = if32.mulresp_msg_result;
        check({tag, "_res"}, res, exp_res);
        if (hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (if32.mulresp_msg_result !== res || if32.mulresp_val !== 1'b1
                    || if32.mulreq_rdy !== 1'b0) stable = 1'b0;
            end
            check({tag, "_hold_stable"}, 64'(stable), 64'd1);
            @(negedge clk);
            if32.mulresp_rdy = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, "_rdy_after"}, {62'd0, if32.mulreq_rdy, if32.mulresp_val}, 64'b10);
        if32.mulresp_rdy = 1'b0;
    endtask

    task automatic mul8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic sgn, input logic [15:0] exp_res);
        int   lat;
        logic [7:0] mb;
        @(negedge clk);
        if8.mulreq_msg_a      = a;
        if8.mulreq_msg_b      = b;
        if8.mulreq_msg_signed = sgn;
        if8.mulreq_val        = 1'b1;
        if8.mulresp_rdy       = 1'b1;
        @(posedge clk); #1;
        if8.mulreq_val = 1'b0;
        lat = 1;
        while (!if8.mulresp_val && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        mb = (sgn && b[7]) ? (~b + 8'd1) : b;
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat(64'(mb), 8)));
        check({tag, "_res"}, 64'(if8.mulresp_msg_result), 64'(exp_res));
        @(posedge clk); #1;
        check({tag, "_rdy_after"}, {62'd0, if8.mulreq_rdy, if8.mulresp_val}, 64'b10);
    endtask

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] res;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int acc[$];
        int lat;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        reset    = 1'b0;
        if32.mulreq_msg_a = '0; if32.mulreq_msg_b = '0; if32.mulreq_msg_signed = 1'b0;
        if32.mulreq_val   = 1'b0; if32.mulresp_rdy = 1'b0;
        if8.mulreq_msg_a  = '0; if8.mulreq_msg_b  = '0; if8.mulreq_msg_signed  = 1'b0;
        if8.mulreq_val    = 1'b0; if8.mulresp_rdy  = 1'b0;

        // While reset is asserted, the design is idle and a request must not be accepted.
        repeat (2) @(posedge clk);
        if32.mulreq_val = 1'b1;
        @(posedge clk); #1;
        check("rst_rdy",    64'(if32.mulreq_rdy), 64'd1);
        check("rst_val",    64'(if32.mulresp_val), 64'd0);
        check("rst_result", if32.mulresp_msg_result, 64'd0);
        if32.mulreq_val = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("rst_no_accept", 64'(if32.mulreq_rdy), 64'd1);

        vecs.push_back('{"u3x4",        32'd3,          32'd4,          1'b0, 64'h0000_0000_0000_000C});
        vecs.push_back('{"s_m3x5",      32'hFFFF_FFFD,  32'd5,          1'b1, 64'hFFFF_FFFF_FFFF_FFF1});
        vecs.push_back('{"s_min_min",   32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000});
        vecs.push_back('{"u_min_min",   32'h8000_0000,  32'h8000_0000,  1'b0, 64'h4000_0000_0000_0000});
        vecs.push_back('{"s_min_x1",    32'h8000_0000,  32'd1,          1'b1, 64'hFFFF_FFFF_8000_0000});
        vecs.push_back('{"s_m1_m1",     32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 64'h0000_0000_0000_0001});
        vecs.push_back('{"s_7_m6",      32'd7,          32'hFFFF_FFFA,  1'b1, 64'hFFFF_FFFF_FFFF_FFD6});
        vecs.push_back('{"u_bx0",       32'h1234_5678,  32'd0,          1'b0, 64'h0000_0000_0000_0000});
        foreach (vecs[i]) mul32(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].res, 0);

        // Response held off for 10 cycles.
        mul32("u_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 10);

        // Back-to-back requests: the interval between acceptance edges is W+2.
        @(negedge clk);
        if32.mulreq_msg_a = 32'd7; if32.mulreq_msg_b = 32'd6; if32.mulreq_msg_signed = 1'b0;
        if32.mulreq_val   = 1'b1;  if32.mulresp_rdy  = 1'b1;
        for (int i = 0; i < 120 && acc.size() < 2; i++) begin
            if (if32.mulreq_rdy) acc.push_back(cyc);
            @(negedge clk);
        end
        if32.mulreq_val = 1'b0;
        check("ii_accepts", 64'(acc.size()), 64'd2);
        if (acc.size() == 2) check("ii_interval", 64'(acc[1] - acc[0]), 64'(exp_lat(64'd6, 32) + 1));
        lat = 0;
        while (!if32.mulresp_val && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ii_second_res", if32.mulresp_msg_result, 64'd42);
        @(posedge clk); #1;
        if32.mulresp_rdy = 1'b0;

        // Reset asserted in CALC cycle 10 discards the operation.
        @(negedge clk);
        if32.mulreq_msg_a = 32'hFFFF_FFFF; if32.mulreq_msg_b = 32'hFFFF_FFFF;
        if32.mulreq_msg_signed = 1'b0; if32.mulreq_val = 1'b1;
        @(posedge clk); #1;
        if32.mulreq_val = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_val",    64'(if32.mulresp_val), 64'd0);
        check("midrst_rdy",    64'(if32.mulreq_rdy),  64'd1);
        check("midrst_result", if32.mulresp_msg_result, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        mul32("post_rst_7x6", 32'd7, 32'd6, 1'b0, 64'd42, 0);

        // W=8 instance
        mul8("w8_s_min_m1", 8'h80, 8'hFF, 1'b1, 16'h0080);
        mul8("w8_u_80_ff",  8'h80, 8'hFF, 1'b0, 16'h7F80);
        mul8("w8_s_m5_3",   8'hFB, 8'h03, 1'b1, 16'hFFF1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
